// File: rtl/mem_wb_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : MEM stage plus MEM/WB pipeline register of a 32-bit pipeline.
//            Holds a 256 x 32 data memory (word index = alu_result_in[9:2],
//            so addresses wrap modulo 1 KiB), resolves the branch decision,
//            registers the write-back fields and selects wb_data.
// Config   : MEM_WAIT_EN - when defined, every load takes two cycles: an
//            IDLE/WAIT FSM raises stall for one cycle and inserts a bubble
//            into MEM/WB. When undefined, stall is tied low and loads
//            complete in one cycle.
// Ports    : clock, reset          rising-edge clock, sync active-high reset
//            alu_result_in [31:0]  ALU result / memory byte address
//            write_data_in [31:0]  store data
//            write_reg_in  [4:0]   destination register
//            branch_target_in      branch target (passed through)
//            pc_plus4_in   [31:0]  jal link value
//            zero_in, branch_in    branch decision inputs
//            mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in[1:0]
//            pc_src, branch_target, stall
//            reg_write_out, write_reg_out, mem_to_reg_out, wb_data
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] write_data_in,
    input  logic [4:0]  write_reg_in,
    input  logic [31:0] branch_target_in,
    input  logic [31:0] pc_plus4_in,
    input  logic        zero_in,
    input  logic        branch_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        reg_write_in,
    input  logic [1:0]  mem_to_reg_in,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        stall,
    output logic        reg_write_out,
    output logic [4:0]  write_reg_out,
    output logic [1:0]  mem_to_reg_out,
    output logic [31:0] wb_data
);

    // ------------------------------------------------------------------
    // Data memory: asynchronous read, synchronous write. The read sees the
    // word before any same-cycle store lands, so a cycle with both
    // mem_read_in and mem_write_in set captures the pre-write word.
    // ------------------------------------------------------------------
    logic [31:0] mem_q [0:255];
    logic [7:0]  w_index;
    logic [31:0] w_read_word;

    assign w_index     = alu_result_in[9:2];
    assign w_read_word = mem_q[w_index];

    always_ff @(posedge clock) begin
        if (!reset && mem_write_in) begin
            mem_q[w_index] <= write_data_in;
        end
    end

    // ------------------------------------------------------------------
    // Branch resolution is purely combinational.
    // ------------------------------------------------------------------
    assign pc_src        = branch_in & zero_in;
    assign branch_target = branch_target_in;

    // ------------------------------------------------------------------
    // Load wait-state control
    // ------------------------------------------------------------------
    logic w_stall;
    logic w_bubble;

`ifdef MEM_WAIT_EN
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    state_e state_q;
    state_e state_d;
    logic   w_load;

    // A cycle with both read and write set is a store and never waits.
    assign w_load = mem_read_in & ~mem_write_in;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        w_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_load) begin
                    w_stall = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The first cycle of a load pushes an empty slot into MEM/WB.
    assign w_bubble = w_stall;
`else
    logic unused_mem_read;

    assign unused_mem_read = mem_read_in;
    assign w_stall         = 1'b0;
    assign w_bubble        = 1'b0;
`endif

    assign stall = w_stall;

    // ------------------------------------------------------------------
    // MEM/WB pipeline register
    // ------------------------------------------------------------------
    logic        reg_write_q,  reg_write_d;
    logic [4:0]  write_reg_q,  write_reg_d;
    logic [1:0]  mem_to_reg_q, mem_to_reg_d;
    logic [31:0] read_data_q,  read_data_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] pc_plus4_q,   pc_plus4_d;

    always_comb begin
        reg_write_d  = reg_write_in;
        write_reg_d  = write_reg_in;
        mem_to_reg_d = mem_to_reg_in;
        read_data_d  = w_read_word;
        alu_result_d = alu_result_in;
        pc_plus4_d   = pc_plus4_in;
        if (w_bubble) begin
            reg_write_d  = 1'b0;
            write_reg_d  = 5'd0;
            mem_to_reg_d = 2'b00;
            read_data_d  = 32'd0;
            alu_result_d = 32'd0;
            pc_plus4_d   = 32'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            reg_write_q  <= 1'b0;
            write_reg_q  <= 5'd0;
            mem_to_reg_q <= 2'b00;
            read_data_q  <= 32'd0;
            alu_result_q <= 32'd0;
            pc_plus4_q   <= 32'd0;
        end else begin
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            mem_to_reg_q <= mem_to_reg_d;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            pc_plus4_q   <= pc_plus4_d;
        end
    end

    assign reg_write_out  = reg_write_q;
    assign write_reg_out  = write_reg_q;
    assign mem_to_reg_out = mem_to_reg_q;

    // Write-back select: 00 ALU, 01 load data, 10 link address, 11 zero.
    always_comb begin
        wb_data = 32'd0;
        case (mem_to_reg_q)
            2'b00:   wb_data = alu_result_q;
            2'b01:   wb_data = read_data_q;
            2'b10:   wb_data = pc_plus4_q;
            default: wb_data = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_stage
// Purpose  : Self-checking bench for mem_wb_stage. Directed vector table,
//            hand-written multi-cycle sequences and a randomized run checked
//            against a behavioural model. Honours MEM_WAIT_EN like the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

`ifdef MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic [31:0] alu_result_in, write_data_in, branch_target_in, pc_plus4_in;
    logic [4:0]  write_reg_in;
    logic        zero_in, branch_in, mem_read_in, mem_write_in, reg_write_in;
    logic [1:0]  mem_to_reg_in;
    logic        pc_src, stall, reg_write_out;
    logic [31:0] branch_target, wb_data;
    logic [4:0]  write_reg_out;
    logic [1:0]  mem_to_reg_out;

    mem_wb_stage dut (
        .clock            (clock),
        .reset            (reset),
        .alu_result_in    (alu_result_in),
        .write_data_in    (write_data_in),
        .write_reg_in     (write_reg_in),
        .branch_target_in (branch_target_in),
        .pc_plus4_in      (pc_plus4_in),
        .zero_in          (zero_in),
        .branch_in        (branch_in),
        .mem_read_in      (mem_read_in),
        .mem_write_in     (mem_write_in),
        .reg_write_in     (reg_write_in),
        .mem_to_reg_in    (mem_to_reg_in),
        .pc_src           (pc_src),
        .branch_target    (branch_target),
        .stall            (stall),
        .reg_write_out    (reg_write_out),
        .write_reg_out    (write_reg_out),
        .mem_to_reg_out   (mem_to_reg_out),
        .wb_data          (wb_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct packed {
        logic        rst;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  wr;
        logic [31:0] tgt;
        logic [31:0] pc4;
        logic        zero;
        logic        br;
        logic        mrd;
        logic        mwr;
        logic        rw;
        logic [1:0]  m2r;
    } in_t;

    typedef struct packed {
        in_t         i;
        logic        e_pc;
        logic [31:0] e_tgt;
        logic        e_stall;
        logic        e_rw;
        logic [4:0]  e_wreg;
        logic [1:0]  e_m2r;
        logic [31:0] e_wb;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Sampled DUT outputs
    logic        s_pc, s_stall, s_rw;
    logic [31:0] s_tgt, s_wb;
    logic [4:0]  s_wreg;
    logic [1:0]  s_m2r;

    // Reference model state and expectations
    logic [31:0] mem_m [0:255];
    bit          waiting = 1'b0;
    logic        m_pc, m_stall, m_rw;
    logic [31:0] m_tgt, m_wb;
    logic [4:0]  m_wreg;
    logic [1:0]  m_m2r;

    function automatic in_t mkin(input logic rst, input logic [31:0] alu,
                                 input logic [31:0] wd, input logic [4:0] wr,
                                 input logic [31:0] tgt, input logic [31:0] pc4,
                                 input logic zero, input logic br,
                                 input logic mrd, input logic mwr,
                                 input logic rw, input logic [1:0] m2r);
        in_t v;
        v.rst = rst; v.alu = alu; v.wd = wd; v.wr = wr; v.tgt = tgt;
        v.pc4 = pc4; v.zero = zero; v.br = br; v.mrd = mrd; v.mwr = mwr;
        v.rw = rw; v.m2r = m2r;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // One clock cycle: drive, sample combinational outputs, let the edge
    // happen, advance the model, sample registered outputs.
    task automatic step(input in_t v);
        logic [31:0] rd;
        @(negedge clock);
        reset = v.rst; alu_result_in = v.alu; write_data_in = v.wd;
        write_reg_in = v.wr; branch_target_in = v.tgt; pc_plus4_in = v.pc4;
        zero_in = v.zero; branch_in = v.br; mem_read_in = v.mrd;
        mem_write_in = v.mwr; reg_write_in = v.rw; mem_to_reg_in = v.m2r;
        #1;
        s_pc = pc_src; s_tgt = branch_target; s_stall = stall;
        m_pc    = v.br & v.zero;
        m_tgt   = v.tgt;
        m_stall = WAIT_EN & ~waiting & v.mrd & ~v.mwr;
        @(posedge clock);
        if (v.rst) begin
            m_rw = 0; m_wreg = 0; m_m2r = 0; m_wb = 0; waiting = 1'b0;
        end else if (m_stall) begin
            m_rw = 0; m_wreg = 0; m_m2r = 0; m_wb = 0; waiting = 1'b1;
        end else begin
            rd     = mem_m[v.alu[9:2]];
            m_rw   = v.rw;
            m_wreg = v.wr;
            m_m2r  = v.m2r;
            case (v.m2r)
                2'd0:    m_wb = v.alu;
                2'd1:    m_wb = rd;
                2'd2:    m_wb = v.pc4;
                default: m_wb = 32'd0;
            endcase
            if (v.mwr) mem_m[v.alu[9:2]] = v.wd;
            waiting = 1'b0;
        end
        #1;
        s_rw = reg_write_out; s_wreg = write_reg_out;
        s_m2r = mem_to_reg_out; s_wb = wb_data;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        step(mkin(0, a, d, 5'd0, 32'd0, 32'd0, 0, 0, 0, 1, 0, 2'd0));
        check("store_no_stall", s_stall, 0);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [4:0] wr,
                           input logic [31:0] req, input string nm);
        in_t v;
        v = mkin(0, a, 32'd0, wr, 32'd0, 32'd0, 0, 0, 1, 0, 1, 2'd1);
`ifdef MEM_WAIT_EN
        step(v);
        check({nm, "_stall_first"}, s_stall, 1);
        check({nm, "_bubble_rw"}, s_rw, 0);
`endif
        step(v);
        check({nm, "_stall_done"}, s_stall, 0);
        check({nm, "_wb"}, s_wb, req);
        check({nm, "_rw"}, s_rw, 1);
        check({nm, "_wreg"}, s_wreg, wr);
    endtask

    vec_t tbl [7];
    in_t  v, last;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset ----
        step(mkin(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0));
        step(mkin(1, 32'h8, 32'h1, 5'd3, 0, 32'h44, 0, 0, 0, 0, 1, 2'd2));
        check("reset_rw", s_rw, 0);
        check("reset_wreg", s_wreg, 0);
        check("reset_m2r", s_m2r, 0);
        check("reset_wb", s_wb, 0);
        check("reset_stall", s_stall, 0);

        // ---- vector table (single-cycle, non-load operations) ----
        tbl[0] = '{mkin(0, 32'hCAFE0001, 0, 5'd3, 32'h0, 32'h4, 0, 0, 0, 0, 1, 2'd0),
                   1'b0, 32'h0, 1'b0, 1'b1, 5'd3, 2'd0, 32'hCAFE0001};
        tbl[1] = '{mkin(0, 32'h8, 0, 5'd0, 32'h40, 32'h8, 1, 1, 0, 0, 0, 2'd0),
                   1'b1, 32'h40, 1'b0, 1'b0, 5'd0, 2'd0, 32'h8};
        tbl[2] = '{mkin(0, 32'hC, 0, 5'd0, 32'h40, 32'h0, 0, 1, 0, 0, 0, 2'd0),
                   1'b0, 32'h40, 1'b0, 1'b0, 5'd0, 2'd0, 32'hC};
        tbl[3] = '{mkin(0, 32'h77, 0, 5'd9, 32'h1234, 32'h0, 1, 0, 0, 0, 1, 2'd0),
                   1'b0, 32'h1234, 1'b0, 1'b1, 5'd9, 2'd0, 32'h77};
        tbl[4] = '{mkin(0, 32'h55, 0, 5'd31, 32'h0, 32'h100, 0, 0, 0, 0, 1, 2'd2),
                   1'b0, 32'h0, 1'b0, 1'b1, 5'd31, 2'd2, 32'h100};
        tbl[5] = '{mkin(0, 32'hFFFF, 0, 5'd7, 32'h0, 32'h200, 0, 0, 0, 0, 1, 2'd3),
                   1'b0, 32'h0, 1'b0, 1'b1, 5'd7, 2'd3, 32'h0};
        tbl[6] = '{mkin(0, 32'h404, 32'h12345678, 5'd0, 32'h0, 32'h0, 0, 0, 0, 1, 0, 2'd0),
                   1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 2'd0, 32'h404};
        for (int k = 0; k < 7; k++) begin
            step(tbl[k].i);
            check($sformatf("vec%0d_pc_src", k), s_pc, tbl[k].e_pc);
            check($sformatf("vec%0d_target", k), s_tgt, tbl[k].e_tgt);
            check($sformatf("vec%0d_stall", k), s_stall, tbl[k].e_stall);
            check($sformatf("vec%0d_rw", k), s_rw, tbl[k].e_rw);
            check($sformatf("vec%0d_wreg", k), s_wreg, tbl[k].e_wreg);
            check($sformatf("vec%0d_m2r", k), s_m2r, tbl[k].e_m2r);
            check($sformatf("vec%0d_wb", k), s_wb, tbl[k].e_wb);
        end

        // ---- address wrap: 0x404 was stored above, read back via 0x004 ----
        do_load(32'h004, 5'd6, 32'h12345678, "wrap");

        // ---- store then load ----
        do_store(32'h10, 32'hDEADBEEF);
        do_load(32'h10, 5'd5, 32'hDEADBEEF, "st_ld");

        // ---- read and write together: store, read data is the old word ----
        do_store(32'h20, 32'hAAAA5555);
        step(mkin(0, 32'h20, 32'h11112222, 5'd8, 0, 0, 0, 0, 1, 1, 1, 2'd1));
        check("rdwr_stall", s_stall, 0);
        check("rdwr_old_word", s_wb, 32'hAAAA5555);
        do_load(32'h20, 5'd8, 32'h11112222, "rdwr_new");

`ifdef MEM_WAIT_EN
        // ---- two back-to-back loads: stall 1,0,1,0 ----
        v = mkin(0, 32'h10, 0, 5'd2, 0, 0, 0, 0, 1, 0, 1, 2'd1);
        step(v);
        check("b2b_stall0", s_stall, 1);
        check("b2b_bubble0", s_rw, 0);
        step(v);
        check("b2b_stall1", s_stall, 0);
        check("b2b_wb1", s_wb, 32'hDEADBEEF);
        v = mkin(0, 32'h20, 0, 5'd3, 0, 0, 0, 0, 1, 0, 1, 2'd1);
        step(v);
        check("b2b_stall2", s_stall, 1);
        check("b2b_bubble2", s_rw, 0);
        step(v);
        check("b2b_stall3", s_stall, 0);
        check("b2b_wb3", s_wb, 32'h11112222);

        // enter WAIT so the following reset lands mid-wait
        step(mkin(0, 32'h10, 0, 5'd4, 0, 0, 0, 0, 1, 0, 1, 2'd1));
        check("rst_wait_enter", s_stall, 1);
`endif
        // ---- reset with a store pending: write blocked, regs cleared ----
        step(mkin(1, 32'h10, 32'hBAD0BAD0, 5'd4, 0, 0, 0, 0, 0, 1, 1, 2'd1));
        check("rst_mid_stall", s_stall, 0);
        check("rst_mid_rw", s_rw, 0);
        check("rst_mid_wreg", s_wreg, 0);
        check("rst_mid_wb", s_wb, 0);
        step(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0));
        check("post_rst_stall", s_stall, 0);
        check("post_rst_rw", s_rw, 0);
        do_load(32'h10, 5'd1, 32'hDEADBEEF, "mem_intact");

        // ---- randomized run against the model ----
        for (int i = 0; i < 256; i++) begin
            step(mkin(0, {22'd0, i[7:0], 2'b00}, $urandom, 5'd0, 0, 0, 0, 0, 0, 1, 0, 2'd0));
        end
        last = mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
        for (int n = 0; n < 400; n++) begin
            if (waiting) begin
                v = last;
                v.rst = ($urandom_range(0, 15) == 0);
            end else begin
                v.rst  = ($urandom_range(0, 19) == 0);
                v.alu  = $urandom;
                v.wd   = $urandom;
                v.wr   = 5'($urandom);
                v.tgt  = $urandom;
                v.pc4  = $urandom;
                v.zero = 1'($urandom);
                v.br   = 1'($urandom);
                v.mrd  = 1'($urandom);
                v.mwr  = 1'($urandom);
                v.rw   = 1'($urandom);
                v.m2r  = 2'($urandom);
            end
            last = v;
            step(v);
            check("rand_pc_src", s_pc, m_pc);
            check("rand_target", s_tgt, m_tgt);
            check("rand_stall", s_stall, m_stall);
            check("rand_rw", s_rw, m_rw);
            check("rand_wreg", s_wreg, m_wreg);
            check("rand_m2r", s_m2r, m_m2r);
            check("rand_wb", s_wb, m_wb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
